// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios PIO blocks: word address map and edge-capture encodings.
// The output PIO uses the same address constants.
package nios_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Right-justify a WIDTH-bit field into a 32-bit bus word, upper bits zero.
  function automatic logic [31:0] pio_zext(input logic [31:0] value, input int width);
    logic [31:0] word_v;
    word_v = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        word_v[i] = value[i];
      end else begin
        word_v[i] = 1'b0;
      end
    end
    return word_v;
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchronizer with one-cycle history, startup inhibit and selectable edge detection.
module pio_sync_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edges
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;
  logic [CNT_W-1:0] inhibit_cnt_r;
  logic             armed_s;
  logic [WIDTH-1:0] raw_edge_s;

  // Synchronizer chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Inhibit counter: holds edges off until the chain and prev carry real pin data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inhibit_cnt_r <= '0;
    end else if (inhibit_cnt_r != CNT_SAT) begin
      inhibit_cnt_r <= inhibit_cnt_r + CNT_W'(1);
    end else begin
      inhibit_cnt_r <= inhibit_cnt_r;
    end
  end

  assign sync    = sync_r[SYNC_STAGES-1];
  assign armed_s = (inhibit_cnt_r == CNT_SAT);

  // Edge term selection, gated by the startup inhibit.
  always_comb begin
    raw_edge_s = '0;
    case (EDGE_TYPE)
      EDGE_RISING:  raw_edge_s = sync & ~prev_r;
      EDGE_FALLING: raw_edge_s = ~sync & prev_r;
      EDGE_ANY:     raw_edge_s = sync ^ prev_r;
      default:      raw_edge_s = sync & ~prev_r;
    endcase
    if (armed_s) begin
      edges = raw_edge_s;
    end else begin
      edges = '0;
    end
  end

endmodule

// File: rtl/nios_pio_in_capture.sv
// Avalon-MM input PIO: synchronized DATA, IRQ mask, sticky write-1-to-clear edge capture
// and a level interrupt to the Nios V.
module nios_pio_in_capture
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] edges_s;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [31:0]      readdata_r;
  logic             rd_sel_s;
  logic             wr_sel_s;
  logic [WIDTH-1:0] edgecap_clr_s;
  logic [WIDTH-1:0] edgecap_nxt_s;
  logic [31:0]      rd_mux_s;
  logic             unused_wdata_s;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync    (sync_s),
    .edges   (edges_s)
  );

  // Bus decode and edge-capture next state; a new edge overrides a same-cycle clear.
  always_comb begin
    rd_sel_s = chipselect & ~read_n;
    wr_sel_s = chipselect & ~write_n;
    if (wr_sel_s && (address == PIO_ADDR_EDGECAP)) begin
      edgecap_clr_s = writedata[WIDTH-1:0];
    end else begin
      edgecap_clr_s = '0;
    end
    edgecap_nxt_s = (edgecap_r & ~edgecap_clr_s) | edges_s;
  end

  // Read mux; reserved and unknown addresses return zero.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (address)
      PIO_ADDR_DATA:    rd_mux_s = pio_zext(32'(sync_s), WIDTH);
      PIO_ADDR_RSVD:    rd_mux_s = 32'h0000_0000;
      PIO_ADDR_IRQMASK: rd_mux_s = pio_zext(32'(irqmask_r), WIDTH);
      PIO_ADDR_EDGECAP: rd_mux_s = pio_zext(32'(edgecap_r), WIDTH);
      default:          rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_r <= '0;
    end else if (wr_sel_s && (address == PIO_ADDR_IRQMASK)) begin
      irqmask_r <= writedata[WIDTH-1:0];
    end else begin
      irqmask_r <= irqmask_r;
    end
  end

  // Sticky edge-capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_r <= '0;
    end else begin
      edgecap_r <= edgecap_nxt_s;
    end
  end

  // Read data register; samples pre-write register contents and holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'h0000_0000;
    end else if (rd_sel_s) begin
      readdata_r <= rd_mux_s;
    end else begin
      readdata_r <= readdata_r;
    end
  end

  assign readdata       = readdata_r;
  assign irq            = |(edgecap_r & irqmask_r);
  assign unused_wdata_s = ^writedata;

endmodule

// File: tb/tb_nios_pio_in_capture.sv
// Directed bench: three instances (rising, falling, any-edge) on a shared Avalon bus.
module tb_nios_pio_in_capture;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             read_n;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in0, in1, in2;
  logic [31:0]      rdata0, rdata1, rdata2;
  logic             irq0, irq1, irq2;
  logic [31:0]      rd0, rd1, rd2;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  nios_pio_in_capture #(.WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata0),
    .in_port(in0), .irq(irq0)
  );
  nios_pio_in_capture #(.WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata1),
    .in_port(in1), .irq(irq1)
  );
  nios_pio_in_capture #(.WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata2),
    .in_port(in2), .irq(irq2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    address = addr; writedata = data; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr);
    @(negedge clk);
    address = addr; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    rd0 = rdata0; rd1 = rdata1; rd2 = rdata2;
  endtask

  task automatic bus_rw(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    address = addr; writedata = data; chipselect = 1'b1; read_n = 1'b0; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    rd0 = rdata0; rd1 = rdata1; rd2 = rdata2;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    writedata = 32'h0; in0 = 10'h3FF; in1 = 10'h0F0; in2 = 10'h000;
    idle(3);
    check_eq("reset_readdata", rdata0, 32'h0);
    check_eq("reset_irq", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    idle(10);

    // Pins high at reset release must read back but never capture.
    bus_read(2'd0);
    check_eq("data_3ff", rd0, 32'h0000_03FF);
    check_eq("data_fall_0f0", rd1, 32'h0000_00F0);
    bus_read(2'd1);
    check_eq("rsvd_zero", rd0, 32'h0);
    bus_read(2'd3);
    check_eq("startup_edgecap_rise", rd0, 32'h0);
    check_eq("startup_edgecap_fall", rd1, 32'h0);
    check_eq("startup_irq", 32'(irq0), 32'h0);

    in0 = 10'h000;
    idle(5);
    bus_read(2'd3);
    check_eq("rise_ignores_fall", rd0, 32'h0);

    // Exact latency: pin changes before E0, irq visible after E2.
    bus_write(2'd2, 32'h001);
    in0 = 10'h001;
    @(negedge clk);
    @(negedge clk);
    check_eq("irq_not_yet", 32'(irq0), 32'h0);
    @(negedge clk);
    check_eq("irq_at_e2", 32'(irq0), 32'h1);
    bus_read(2'd3);
    check_eq("edgecap_001", rd0, 32'h0000_0001);
    bus_write(2'd3, 32'h001);
    check_eq("irq_after_clear", 32'(irq0), 32'h0);
    bus_read(2'd3);
    check_eq("edgecap_cleared", rd0, 32'h0);

    // Simultaneous read/write returns the pre-write value.
    bus_rw(2'd2, 32'h000);
    check_eq("rw_prewrite", rd0, 32'h0000_0001);
    bus_read(2'd2);
    check_eq("mask_zero", rd0, 32'h0);

    in0 = 10'h021;
    idle(4);
    bus_read(2'd3);
    check_eq("edgecap_bit5", rd0, 32'h0000_0020);
    check_eq("masked_irq_low", 32'(irq0), 32'h0);
    idle(3);
    check_eq("readdata_holds", rdata0, 32'h0000_0020);
    bus_write(2'd2, 32'h020);
    check_eq("irq_after_unmask", 32'(irq0), 32'h1);

    // Clear and new edge on bit 2 in the same cycle: edge wins.
    bus_write(2'd3, 32'h3FF);
    check_eq("irq_after_clear_all", 32'(irq0), 32'h0);
    @(negedge clk);
    in0 = 10'h025;
    @(negedge clk);
    @(negedge clk);
    address = 2'd3; writedata = 32'h004; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd3);
    check_eq("edge_beats_clear", rd0, 32'h0000_0004);
    bus_write(2'd3, 32'h004);
    bus_read(2'd3);
    check_eq("bit2_cleared", rd0, 32'h0);

    // Falling and any-edge instances.
    in1 = 10'h000;
    in2 = 10'h00F;
    idle(4);
    bus_read(2'd3);
    check_eq("fall_captures", rd1, 32'h0000_00F0);
    check_eq("any_rise_captures", rd2, 32'h0000_000F);
    bus_write(2'd3, 32'h3FF);
    in1 = 10'h0F0;
    in2 = 10'h000;
    idle(4);
    bus_read(2'd3);
    check_eq("fall_ignores_rise", rd1, 32'h0);
    check_eq("any_fall_captures", rd2, 32'h0000_000F);

    // Asynchronous reset with irq high and all bits captured.
    bus_write(2'd2, 32'h3FF);
    in0 = 10'h000;
    idle(4);
    bus_write(2'd3, 32'h3FF);
    in0 = 10'h3FF;
    idle(4);
    bus_read(2'd3);
    check_eq("edgecap_all", rd0, 32'h0000_03FF);
    check_eq("irq_all", 32'(irq0), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_irq_drop", 32'(irq0), 32'h0);
    check_eq("async_readdata_drop", rdata0, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(6);
    bus_read(2'd2);
    check_eq("post_reset_mask", rd0, 32'h0);
    bus_read(2'd3);
    check_eq("post_reset_edgecap", rd0, 32'h0);
    bus_read(2'd1);
    check_eq("post_reset_rsvd", rd0, 32'h0);
    check_eq("post_reset_irq", 32'(irq0), 32'h0);
    bus_read(2'd0);
    check_eq("post_reset_data", rd0, 32'h0000_03FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
